// File: rtl/var_mod_counter_gen_pkg.sv
// Shared definitions for the variable-modulus counter family:
// modulus-select encodings, direction constants and preset helpers.
package var_mod_counter_gen_pkg;

  typedef enum logic [1:0] {
    MODSEL_A = 2'b00,
    MODSEL_B = 2'b01,
    MODSEL_C = 2'b10,
    MODSEL_D = 2'b11
  } modsel_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

  // A modulus of exactly 2**width yields an all-ones MAX after truncation.
  function automatic bit mod_ok(input int width, input int modv);
    return (modv >= 2) && (modv <= (1 << width));
  endfunction

endpackage

// File: rtl/var_mod_sel.sv
// Modulus preset mux: maps SW onto the terminal value MAX = MODsel-1.
// Shared with the display decoder, so it carries its own parameter checks.
module var_mod_sel
  import var_mod_counter_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MOD0  = 6,
  parameter int MOD1  = 8,
  parameter int MOD2  = 10,
  parameter int MOD3  = 15
) (
  input  logic [1:0]       sw,
  output logic [WIDTH-1:0] max
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("var_mod_sel: WIDTH %0d outside 2..16", WIDTH);
  end
  if (!mod_ok(WIDTH, MOD0)) begin : g_bad_mod0
    $error("var_mod_sel: MOD0 %0d illegal for WIDTH %0d", MOD0, WIDTH);
  end
  if (!mod_ok(WIDTH, MOD1)) begin : g_bad_mod1
    $error("var_mod_sel: MOD1 %0d illegal for WIDTH %0d", MOD1, WIDTH);
  end
  if (!mod_ok(WIDTH, MOD2)) begin : g_bad_mod2
    $error("var_mod_sel: MOD2 %0d illegal for WIDTH %0d", MOD2, WIDTH);
  end
  if (!mod_ok(WIDTH, MOD3)) begin : g_bad_mod3
    $error("var_mod_sel: MOD3 %0d illegal for WIDTH %0d", MOD3, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAX0 = WIDTH'(MOD0 - 1);
  localparam logic [WIDTH-1:0] MAX1 = WIDTH'(MOD1 - 1);
  localparam logic [WIDTH-1:0] MAX2 = WIDTH'(MOD2 - 1);
  localparam logic [WIDTH-1:0] MAX3 = WIDTH'(MOD3 - 1);

  always_comb begin
    max = MAX0;
    case (modsel_e'(sw))
      MODSEL_A: max = MAX0;
      MODSEL_B: max = MAX1;
      MODSEL_C: max = MAX2;
      MODSEL_D: max = MAX3;
      default:  max = MAX0;
    endcase
  end

endmodule

// File: rtl/var_mod_counter_gen.sv
// WIDTH-bit up/down counter with run-time modulus select, clamped parallel load,
// combinational terminal count for synchronous cascades and a registered carry/borrow pulse.
module var_mod_counter_gen
  import var_mod_counter_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MOD0  = 6,
  parameter int MOD1  = 8,
  parameter int MOD2  = 10,
  parameter int MOD3  = 15
) (
  input  logic             CP,
  input  logic             CLR,
  input  logic             En,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       SW,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CO
);

  logic [WIDTH-1:0] max;
  logic             at_top;
  logic             at_zero;

  var_mod_sel #(
    .WIDTH (WIDTH),
    .MOD0  (MOD0),
    .MOD1  (MOD1),
    .MOD2  (MOD2),
    .MOD3  (MOD3)
  ) u_sel (
    .sw  (SW),
    .max (max)
  );

  // SW is not latched, so Q can sit above MAX after a preset change.
  assign at_top  = (Q >= max);
  assign at_zero = (Q == '0);

  assign TC = En & (((UP == DIR_UP) & at_top) | ((UP == DIR_DN) & at_zero));

  always_ff @(posedge CP or posedge CLR) begin
    if (CLR) begin
      Q  <= '0;
      CO <= 1'b0;
    end else if (LD) begin
      Q  <= (D > max) ? max : D;
      CO <= 1'b0;
    end else if (En) begin
      if (UP == DIR_UP) begin
        if (at_top) begin
          Q  <= '0;
          CO <= 1'b1;
        end else begin
          Q  <= Q + 1'b1;
          CO <= 1'b0;
        end
      end else begin
        if (at_zero) begin
          Q  <= max;
          CO <= 1'b1;
        end else if (Q > max) begin
          Q  <= max;
          CO <= 1'b0;
        end else begin
          Q  <= Q - 1'b1;
          CO <= 1'b0;
        end
      end
    end else begin
      CO <= 1'b0;
    end
  end

endmodule

// File: tb/tb_var_mod_counter_gen.sv
// Directed vector table plus hand sequences for reset, cascade and the 4-bit full-range case.
module tb_var_mod_counter_gen;
  import var_mod_counter_gen_pkg::*;

  int n_run  = 0;
  int n_fail = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main 8-bit instance
  logic       clr, en, up, ld;
  logic [7:0] d, q;
  logic [1:0] sw;
  logic       tc, co;

  var_mod_counter_gen #(.WIDTH(8)) dut (
    .CP(clk), .CLR(clr), .En(en), .UP(up), .LD(ld), .D(d), .SW(sw),
    .Q(q), .TC(tc), .CO(co)
  );

  // two-digit cascade
  logic       c_clr, c_en;
  logic [7:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_co, hi_co;

  var_mod_counter_gen #(.WIDTH(8)) u_lo (
    .CP(clk), .CLR(c_clr), .En(c_en), .UP(1'b1), .LD(1'b0), .D(8'd0), .SW(2'b10),
    .Q(lo_q), .TC(lo_tc), .CO(lo_co)
  );
  var_mod_counter_gen #(.WIDTH(8)) u_hi (
    .CP(clk), .CLR(c_clr), .En(lo_tc), .UP(1'b1), .LD(1'b0), .D(8'd0), .SW(2'b10),
    .Q(hi_q), .TC(hi_tc), .CO(hi_co)
  );

  // 4-bit instance with a full 2**WIDTH modulus
  logic       s_clr, s_en, s_up, s_ld;
  logic [3:0] s_d, s_q;
  logic [1:0] s_sw;
  logic       s_tc, s_co;

  var_mod_counter_gen #(.WIDTH(4), .MOD3(16)) u_small (
    .CP(clk), .CLR(s_clr), .En(s_en), .UP(s_up), .LD(s_ld), .D(s_d), .SW(s_sw),
    .Q(s_q), .TC(s_tc), .CO(s_co)
  );

  typedef struct {
    logic       en;
    logic       up;
    logic       ld;
    logic [7:0] d;
    logic [1:0] sw;
    logic       tc;
    logic [7:0] q;
    logic       co;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic e, input logic u, input logic l, input logic [7:0] dv,
                              input logic [1:0] s, input logic t, input logic [7:0] qv,
                              input logic c);
    vec_t v;
    v.en = e; v.up = u; v.ld = l; v.d = dv; v.sw = s; v.tc = t; v.q = qv; v.co = c;
    vecs.push_back(v);
  endfunction

  int hi_pulses, lo_pulses;
  int mq, mmax;
  logic mco, mtc;

  initial begin
    clr = 0; en = 0; up = 1; ld = 0; d = 0; sw = 0;
    c_clr = 1; c_en = 0;
    s_clr = 1; s_en = 0; s_up = 1; s_ld = 0; s_d = 0; s_sw = 0;

    //     en up ld d    sw    tc  q   co
    add(1, 1, 0, 0,   2'b00, 0,  1, 0);
    add(1, 1, 0, 0,   2'b00, 0,  2, 0);
    add(1, 1, 0, 0,   2'b00, 0,  3, 0);
    add(1, 1, 0, 0,   2'b00, 0,  4, 0);
    add(1, 1, 0, 0,   2'b00, 0,  5, 0);
    add(1, 1, 0, 0,   2'b00, 1,  0, 1);
    add(1, 1, 0, 0,   2'b00, 0,  1, 0);
    add(1, 0, 0, 0,   2'b11, 0,  0, 0);
    add(1, 0, 0, 0,   2'b11, 1, 14, 1);
    add(1, 0, 0, 0,   2'b11, 0, 13, 0);
    add(1, 0, 0, 0,   2'b11, 0, 12, 0);
    add(0, 0, 1, 7,   2'b10, 0,  7, 0);
    add(0, 0, 1, 12,  2'b10, 0,  9, 0);
    add(1, 1, 1, 3,   2'b10, 1,  3, 0);
    add(0, 1, 0, 0,   2'b10, 0,  3, 0);
    add(0, 1, 1, 9,   2'b10, 0,  9, 0);
    add(1, 1, 0, 0,   2'b00, 1,  0, 1);
    add(0, 1, 1, 9,   2'b10, 0,  9, 0);
    add(1, 0, 0, 0,   2'b00, 0,  5, 0);
    add(1, 0, 0, 0,   2'b00, 0,  4, 0);
    add(0, 0, 0, 0,   2'b00, 0,  4, 0);
    add(0, 0, 0, 0,   2'b00, 0,  4, 0);
    add(0, 0, 0, 0,   2'b00, 0,  4, 0);
    add(0, 1, 1, 255, 2'b01, 0,  7, 0);
    add(1, 1, 0, 0,   2'b01, 1,  0, 1);
    add(0, 1, 0, 0,   2'b01, 0,  0, 0);
    add(1, 1, 0, 0,   2'b11, 0,  1, 0);

    // asynchronous reset between edges
    #7 clr = 1;
    #1 chk("reset_q", 16'(q), 16'd0);
    chk("reset_co", 16'(co), 16'd0);
    @(negedge clk);
    clr = 0; c_clr = 0; s_clr = 0;

    foreach (vecs[i]) begin
      @(negedge clk);
      en = vecs[i].en; up = vecs[i].up; ld = vecs[i].ld; d = vecs[i].d; sw = vecs[i].sw;
      #1 chk($sformatf("vec%0d_tc", i), 16'(tc), 16'(vecs[i].tc));
      @(posedge clk);
      #1 chk($sformatf("vec%0d_q", i), 16'(q), 16'(vecs[i].q));
      chk($sformatf("vec%0d_co", i), 16'(co), 16'(vecs[i].co));
    end

    // CLR clears a live CO pulse immediately and beats a pending load
    @(negedge clk);
    en = 0; ld = 1; d = 9; sw = 2'b10;
    @(negedge clk);
    en = 1; up = 1; ld = 0;
    @(posedge clk);
    #1 chk("pre_clr_co", 16'(co), 16'd1);
    #2 clr = 1; ld = 1; d = 7;
    #1 chk("clr_async_co", 16'(co), 16'd0);
    chk("clr_async_q", 16'(q), 16'd0);
    @(posedge clk);
    #1 chk("clr_beats_ld", 16'(q), 16'd0);
    @(negedge clk);
    clr = 0;
    @(posedge clk);
    #1 chk("post_clr_ld", 16'(q), 16'd7);
    @(negedge clk);
    ld = 0; en = 0;

    // cascade: 125 edges -> high:low = 2:5, one high carry
    hi_pulses = 0; lo_pulses = 0;
    c_en = 1;
    for (int i = 0; i < 125; i++) begin
      @(posedge clk);
      #1;
      if (hi_co) hi_pulses++;
      if (lo_co) lo_pulses++;
      if (i == 99) begin
        chk("casc100_lo", 16'(lo_q), 16'd0);
        chk("casc100_hi", 16'(hi_q), 16'd0);
      end
    end
    chk("casc_lo", 16'(lo_q), 16'd5);
    chk("casc_hi", 16'(hi_q), 16'd2);
    chk("casc_hi_co", 16'(hi_pulses), 16'd1);
    chk("casc_lo_co", 16'(lo_pulses), 16'd12);
    @(negedge clk);
    c_en = 0;
    repeat (3) @(posedge clk);
    #1 chk("casc_hold_lo", 16'(lo_q), 16'd5);
    chk("casc_hold_hi", 16'(hi_q), 16'd2);

    // 4-bit, MOD3=16: 15 -> 0 wraps on the all-ones boundary
    @(negedge clk);
    s_sw = 2'b11; s_ld = 1; s_d = 4'd15;
    @(posedge clk);
    #1 chk("w4_load15", 16'(s_q), 16'd15);
    @(negedge clk);
    s_ld = 0; s_en = 1; s_up = 1;
    #1 chk("w4_tc", 16'(s_tc), 16'd1);
    @(posedge clk);
    #1 chk("w4_wrap_q", 16'(s_q), 16'd0);
    chk("w4_wrap_co", 16'(s_co), 16'd1);
    chk("w4_no_x", 16'($isunknown({s_q, s_co, s_tc})), 16'd0);

    // random ops against a behavioural model
    mq = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      s_sw = 2'($urandom_range(0, 3));
      s_up = 1'($urandom_range(0, 1));
      s_en = ($urandom_range(0, 3) != 0);
      s_ld = ($urandom_range(0, 5) == 0);
      s_d  = 4'($urandom_range(0, 15));
      mmax = (s_sw == 2'd0) ? 5 : (s_sw == 2'd1) ? 7 : (s_sw == 2'd2) ? 9 : 15;
      mtc = s_en && ((s_up && mq >= mmax) || (!s_up && mq == 0));
      mco = 0;
      if (s_ld) mq = (int'(s_d) > mmax) ? mmax : int'(s_d);
      else if (s_en && s_up) begin
        if (mq >= mmax) begin mq = 0; mco = 1; end
        else mq = mq + 1;
      end else if (s_en) begin
        if (mq == 0) begin mq = mmax; mco = 1; end
        else if (mq > mmax) mq = mmax;
        else mq = mq - 1;
      end
      #1 chk($sformatf("rnd%0d_tc", i), 16'(s_tc), 16'(mtc));
      @(posedge clk);
      #1 chk($sformatf("rnd%0d_q", i), 16'(s_q), 16'(mq));
      chk($sformatf("rnd%0d_co", i), 16'(s_co), 16'(mco));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
